// File: rtl/stream_arbiter_tmr.sv
// stream_arbiter_tmr
//
// Two-input round-robin arbiter that shares one registered 8-bit
// valid/ready stream between requester 0 and requester 1. A grant lasts
// until the owner drops valid or BURST_MAX beats have been sent. After that
// the FSM spends one cycle in IDLE and re-arbitrates. When both requesters
// are waiting, the requester that was not served last wins.
//
// The arbitration state (FSM state, last_served, beat_cnt) is held in three
// copies. The logic always works from the bitwise majority of those copies,
// and every copy is rewritten with the voted next value on each cycle.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in0_valid/data/ready     requester 0 stream (ready is an output)
//   in1_valid/data/ready     requester 1 stream (ready is an output)
//   out_valid/data/src       registered downstream stream; src = requester index
//   out_ready                downstream accept
//   seu_inject[2:0]          test hook: bit k flips state bit 0 as copy k loads
//   seu_err                  sticky: copies disagreed or voted state was illegal

module stream_arbiter_tmr #(
   parameter int BURST_MAX = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in0_valid,
   input  logic [7:0] in0_data,
   output logic       in0_ready,
   input  logic       in1_valid,
   input  logic [7:0] in1_data,
   output logic       in1_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_src,
   input  logic       out_ready,
   input  logic [2:0] seu_inject,
   output logic       seu_err
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } state_t;

   localparam logic [3:0] LAST_BEAT = 4'(BURST_MAX - 1);

   logic [1:0] state_cp [3];
   logic       last_cp  [3];
   logic [3:0] beat_cp  [3];

   logic [1:0] state_vote;
   logic       last_vote;
   logic [3:0] beat_vote;
   logic       state_illegal;
   logic       copy_mismatch;
   state_t     state_cur;

   state_t     state_nxt;
   logic       last_nxt;
   logic [3:0] beat_nxt;
   logic       cap;
   logic       xfer;
   logic       xfer_src;
   logic [7:0] xfer_data;

   // Bitwise 2-of-3 vote over each triplicated field. The voted value masks a
   // single upset. A disagreement between any pair of copies is reported as
   // an error, whether or not the vote can correct it. The unused encoding
   // 2'b11 can only come from upsets, so it is run as IDLE. That drops any
   // grant in progress and re-arbitrates cleanly on the next cycle.
   always_comb begin
      state_vote    = (state_cp[0] & state_cp[1]) | (state_cp[0] & state_cp[2]) |
                      (state_cp[1] & state_cp[2]);
      last_vote     = (last_cp[0] & last_cp[1]) | (last_cp[0] & last_cp[2]) |
                      (last_cp[1] & last_cp[2]);
      beat_vote     = (beat_cp[0] & beat_cp[1]) | (beat_cp[0] & beat_cp[2]) |
                      (beat_cp[1] & beat_cp[2]);
      state_illegal = (state_vote == 2'b11);
      state_cur     = state_illegal ? IDLE : state_t'(state_vote);
      copy_mismatch = (state_cp[0] != state_cp[1]) || (state_cp[0] != state_cp[2]) ||
                      (last_cp[0]  != last_cp[1])  || (last_cp[0]  != last_cp[2])  ||
                      (beat_cp[0]  != beat_cp[1])  || (beat_cp[0]  != beat_cp[2]);
   end

   // The output register may load when it is empty or is being drained in
   // this cycle.
   assign cap = !out_valid || out_ready;

   // Next-state and handshake logic. IDLE only arbitrates and never
   // transfers, which gives the one-cycle bubble between grants. A granted
   // requester sees ready whenever the output register can load. The grant
   // ends after the last beat of a burst. It also ends when the output could
   // accept a beat but the owner has no data. When the output register is
   // stalled, everything holds.
   always_comb begin
      state_nxt = state_cur;
      last_nxt  = last_vote;
      beat_nxt  = beat_vote;
      xfer      = 1'b0;
      xfer_src  = 1'b0;
      xfer_data = in0_data;
      in0_ready = 1'b0;
      in1_ready = 1'b0;
      case (state_cur)
         IDLE: begin
            beat_nxt = 4'd0;
            if (in0_valid && in1_valid) begin
               state_nxt = last_vote ? GNT0 : GNT1;
            end else if (in0_valid) begin
               state_nxt = GNT0;
            end else if (in1_valid) begin
               state_nxt = GNT1;
            end
         end
         GNT0: begin
            in0_ready = cap;
            if (cap) begin
               if (in0_valid) begin
                  xfer      = 1'b1;
                  xfer_src  = 1'b0;
                  xfer_data = in0_data;
                  if (beat_vote == LAST_BEAT) begin
                     state_nxt = IDLE;
                     last_nxt  = 1'b0;
                     beat_nxt  = 4'd0;
                  end else begin
                     beat_nxt = beat_vote + 4'd1;
                  end
               end else begin
                  state_nxt = IDLE;
                  last_nxt  = 1'b0;
                  beat_nxt  = 4'd0;
               end
            end
         end
         GNT1: begin
            in1_ready = cap;
            if (cap) begin
               if (in1_valid) begin
                  xfer      = 1'b1;
                  xfer_src  = 1'b1;
                  xfer_data = in1_data;
                  if (beat_vote == LAST_BEAT) begin
                     state_nxt = IDLE;
                     last_nxt  = 1'b1;
                     beat_nxt  = 4'd0;
                  end else begin
                     beat_nxt = beat_vote + 4'd1;
                  end
               end else begin
                  state_nxt = IDLE;
                  last_nxt  = 1'b1;
                  beat_nxt  = 4'd0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register: all three copies load the same voted next value, which
   // scrubs any earlier upset. The test hook inverts state bit 0 in the
   // selected copies only. One corrupted copy is therefore outvoted, while
   // two corrupted copies take over the vote.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            state_cp[k] <= IDLE;
            last_cp[k]  <= 1'b1;
            beat_cp[k]  <= 4'd0;
         end else begin
            state_cp[k] <= state_nxt ^ {1'b0, seu_inject[k]};
            last_cp[k]  <= last_nxt;
            beat_cp[k]  <= beat_nxt;
         end
      end
   end

   // Downstream output register. While stalled (valid and not ready) it holds
   // its contents. Otherwise it takes the accepted beat, or empties when no
   // beat was accepted. out_data keeps its last value while out_valid is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= 8'd0;
         out_src   <= 1'b0;
      end else if (cap) begin
         out_valid <= xfer;
         if (xfer) begin
            out_data <= xfer_data;
            out_src  <= xfer_src;
         end
      end
   end

   // Sticky error flag. It records any copy disagreement or illegal voted
   // encoding seen in the previous cycle, and clears only on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         seu_err <= 1'b0;
      end else if (copy_mismatch || state_illegal) begin
         seu_err <= 1'b1;
      end
   end

endmodule

// File: doc/stream_arbiter_tmr.md
STREAM_ARBITER_TMR -- requirements
Module: stream_arbiter_tmr

Interface
REQ-001 Parameter BURST_MAX, default 4, sets the maximum beats per grant (legal range 1..15).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in0_valid / in0_data / in0_ready  input / input / output  1 / 8 / 1  requester 0 stream.
REQ-005 in1_valid / in1_data / in1_ready  input / input / output  1 / 8 / 1  requester 1 stream.
REQ-006 out_valid / out_data / out_src  output  1 / 8 / 1  registered shared downstream stream; out_src is the requester index of out_data.
REQ-007 out_ready  input  1  downstream accept.
REQ-008 seu_inject  input  3  test-only; bit k corrupts state copy k (see REQ-021).
REQ-009 seu_err  output  1  sticky flag: triplicated-state mismatch detected.

Function
REQ-010 The block SHALL share the 8-bit downstream channel between two valid/ready requesters using a round-robin FSM with states IDLE, GNT0 and GNT1.
REQ-011 A stream transfer SHALL occur on a cycle where valid and ready are both high; data SHALL be neither dropped nor duplicated.
REQ-012 The output register SHALL be able to load when cap = !out_valid || out_ready.
REQ-013 inX_ready SHALL equal (state == GNTX) && cap; it SHALL be 0 in IDLE and for the non-granted requester.
REQ-014 In IDLE: only in0_valid -> GNT0; only in1_valid -> GNT1; both -> the requester not equal to last_served; neither -> stay in IDLE.
REQ-015 On a transfer, out_data <= inX_data, out_src <= X, out_valid <= 1, and beat_cnt increments.
REQ-016 When cap is high and no transfer occurs, out_valid SHALL go to 0.
REQ-017 In GNTX, a transfer with beat_cnt == BURST_MAX-1 SHALL move to IDLE, set last_served <= X and clear beat_cnt.
REQ-018 In GNTX, cap high with inX_valid low SHALL release the grant to IDLE, set last_served <= X and clear beat_cnt; cap low SHALL hold the state.
REQ-019 Latency: a beat accepted at edge N SHALL appear on out_valid/out_data in cycle N+1. A request first seen in IDLE SHALL be granted one cycle later (one bubble per arbitration).
REQ-020 The FSM state (2 bits), last_served and beat_cnt SHALL each be stored in three copies. The logic SHALL use the bitwise majority vote, and every copy SHALL be rewritten each cycle with the voted next value (continuous scrub).
REQ-021 When seu_inject[k] is high in cycle N, copy k SHALL load the voted next state with state bit 0 inverted at edge N. The voted value SHALL be unaffected.
REQ-022 seu_err SHALL be set one cycle after any copy-pair disagreement in any triplicated field, and SHALL hold until rst.
REQ-023 Mismatches in two copies of the same bit are uncorrectable; the voted value SHALL still be used and seu_err SHALL be set.
REQ-024 An illegal voted state encoding (2'b11) SHALL be treated as IDLE and SHALL set seu_err.
REQ-025 Output SHALL remain stable while out_valid && !out_ready.

Reset
REQ-026 While rst is high at an edge: state = IDLE, last_served = 1 (requester 0 wins the first tie), beat_cnt = 0, out_valid = 0, out_data = 0, out_src = 0, seu_err = 0, in0_ready = in1_ready = 0.
REQ-027 rst asserted during a burst SHALL abort it; any beat held in the output register is discarded, and no in_ready SHALL be high in the cycle after the reset edge.

Verification
REQ-028 The bench SHALL cover the tie case: both requesters valid continuously with out_ready = 1 and BURST_MAX = 4 -> output 0,0,0,0,(bubble),1,1,1,1,(bubble),0,... with matching out_src.
REQ-029 The bench SHALL cover a single requester: in1 sends 0xA5 then drops valid -> out_data = 0xA5, out_src = 1 two cycles after in1_valid rises; FSM returns to IDLE.
REQ-030 The bench SHALL cover backpressure: out_ready = 0 for 5 cycles mid-burst -> out_data held, inX_ready = 0, beat_cnt frozen; the burst resumes with no loss.
REQ-031 The bench SHALL cover single-copy injection: pulse seu_inject = 3'b010 during GNT0 -> traffic unchanged, seu_err = 1 two cycles later and sticky.
REQ-032 The bench SHALL cover double-copy injection to reach encoding 2'b11: force two copies -> FSM behaves as IDLE and seu_err = 1.
REQ-033 The bench SHALL cover reset mid-burst: assert rst after beat 2 of 4 -> next cycle out_valid = 0, state IDLE, and the first tie afterwards goes to requester 0.
